// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared state, counter types and length helper for the SC run controller
package sc_pkg;

    localparam int SC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sc_run_state_e;

    // Counter word wide enough to hold 2^SC_WIDTH.
    typedef logic [SC_WIDTH:0] sc_count_t;

    function automatic int unsigned max_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// rtl/sc_ones_counter.sv - per-input ones accumulator with synchronous clear and enable
module sc_ones_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH:0]   count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + (WIDTH+1)'(1);
        end
    end

endmodule

// File: rtl/sc_run_ctrl.sv
// rtl/sc_run_ctrl.sv - sequences one SC evaluation: load SNG, count ones for len cycles, respond
module sc_run_ctrl
    import sc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0]       req_bxs,
    input  logic [WIDTH:0]                    req_len,
    input  logic                              abort,
    output logic                              sng_rst_n,
    output logic [NUM_INPUTS*WIDTH-1:0]       sng_bxs,
    input  logic [NUM_INPUTS-1:0]             sng_xs,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [NUM_INPUTS*(WIDTH+1)-1:0]   rsp_counts,
    output logic [WIDTH:0]                    rsp_cycles,
    output logic                              rsp_aborted
);

    localparam logic [WIDTH:0] MAX_LEN = (WIDTH+1)'(max_len(WIDTH));

    sc_run_state_e  state;
    sc_run_state_e  next_state;
    logic [WIDTH:0] len_q;
    logic [WIDTH:0] eff_len;
    logic [WIDTH:0] cycles_inc;
    logic           last;
    logic           accept;
    logic           sample;
    logic           set_aborted;

    always_comb begin
        eff_len = req_len;
        if (req_len == '0 || req_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    // rsp_cycles doubles as the live sample counter while running.
    assign cycles_inc = rsp_cycles + (WIDTH+1)'(1);
    assign last       = (cycles_inc == len_q);

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        sample      = 1'b0;
        set_aborted = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    set_aborted = 1'b1;
                    next_state  = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                // An abort landing on the final sample loses to normal completion.
                if (abort && !last) begin
                    set_aborted = 1'b1;
                    next_state  = DONE;
                end else begin
                    sample = 1'b1;
                    if (last) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (rsp_valid && rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are decoded from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b1;
            sng_rst_n   <= 1'b1;
            sng_bxs     <= '0;
            rsp_valid   <= 1'b0;
            rsp_cycles  <= '0;
            rsp_aborted <= 1'b0;
            len_q       <= '0;
        end else begin
            req_ready <= (next_state == IDLE);
            sng_rst_n <= (next_state != LOAD);
            rsp_valid <= (next_state == DONE);
            if (accept) begin
                sng_bxs     <= req_bxs;
                len_q       <= eff_len;
                rsp_cycles  <= '0;
                rsp_aborted <= 1'b0;
            end else begin
                if (sample) begin
                    rsp_cycles <= cycles_inc;
                end
                if (set_aborted) begin
                    rsp_aborted <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cnt
        sc_ones_counter #(
            .WIDTH (WIDTH)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (accept),
            .en    (sample & sng_xs[i]),
            .count (rsp_counts[i*(WIDTH+1) +: WIDTH+1])
        );
    end

endmodule

// File: tb/tb_sc_run_ctrl.sv
// tb/tb_sc_run_ctrl.sv - scoreboard bench for sc_run_ctrl with a reset-driven SNG stand-in
module tb_sc_run_ctrl;
    import sc_pkg::*;

    localparam int W = 8;
    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [N*W-1:0]    req_bxs = '0;
    logic [W:0]        req_len = '0;
    logic              abort = 1'b0;
    logic              sng_rst_n;
    logic [N*W-1:0]    sng_bxs;
    logic [N-1:0]      sng_xs = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [N*(W+1)-1:0] rsp_counts;
    logic [W:0]        rsp_cycles;
    logic              rsp_aborted;

    always #5 clk = ~clk;

    sc_run_ctrl #(
        .WIDTH      (W),
        .NUM_INPUTS (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_bxs     (req_bxs),
        .req_len     (req_len),
        .abort       (abort),
        .sng_rst_n   (sng_rst_n),
        .sng_bxs     (sng_bxs),
        .sng_xs      (sng_xs),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_counts  (rsp_counts),
        .rsp_cycles  (rsp_cycles),
        .rsp_aborted (rsp_aborted)
    );

    typedef struct {
        sc_count_t c0;
        sc_count_t c1;
        sc_count_t cyc;
        logic      ab;
        int        lat;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [15:0]   cur_bxs;
    int            cur_ones0;
    int            cur_ones1;
    int            cur_abort;
    bit            was_reset;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: clamp length, cut short on abort unless it hits the last sample.
    task automatic push_exp(input logic [8:0] len, input int ones0, input int ones1, input int abort_at);
        exp_t e;
        int   eff;
        int   smp;
        eff = (len == 9'd0 || len > 9'd256) ? 256 : int'(len);
        if (abort_at >= 1 && abort_at < eff) begin
            smp   = abort_at - 1;
            e.ab  = 1'b1;
            e.lat = abort_at + 2;
        end else begin
            smp   = eff;
            e.ab  = 1'b0;
            e.lat = eff + 2;
        end
        e.c0  = sc_count_t'((ones0 < smp) ? ones0 : smp);
        e.c1  = sc_count_t'((ones1 < smp) ? ones1 : smp);
        e.cyc = sc_count_t'(smp);
        sb.push_back(e);
    endtask

    task automatic prep_req(input logic [15:0] bxs, input logic [8:0] len, input int o0, input int o1, input int ab);
        push_exp(len, o0, o1, ab);
        cur_bxs   = bxs;
        cur_ones0 = o0;
        cur_ones1 = o1;
        cur_abort = ab;
        req_bxs   = bxs;
        req_len   = len;
        req_valid = 1'b1;
    endtask

    task automatic start_req(input logic [15:0] bxs, input logic [8:0] len, input int o0, input int o1, input int ab);
        int guard;
        prep_req(bxs, len, o0, o1, ab);
        guard = 0;
        while (!req_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("req_ready_wait", req_ready, 1);
    endtask

    // Drives the SNG stand-in: sample k of a run is 1 on input i while k <= ones_i.
    task automatic run_wait(input int reset_at);
        int   cnt;
        int   low;
        int   idx;
        exp_t e;
        cnt = 0;
        low = 0;
        idx = 0;
        was_reset = 1'b0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                req_valid = 1'b0;
                check_eq("sng_bxs_load", sng_bxs, cur_bxs);
            end
            if (!sng_rst_n) begin
                low++;
                idx    = 1;
                sng_xs = '0;
                abort  = 1'b0;
            end else if (idx > 0) begin
                sng_xs[0] = (idx <= cur_ones0);
                sng_xs[1] = (idx <= cur_ones1);
                abort     = (idx == cur_abort);
                if (idx == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq("rst_outputs",
                             {req_ready, sng_rst_n, sng_bxs, rsp_valid, rsp_counts, rsp_cycles, rsp_aborted},
                             {1'b1, 1'b1, 16'h0, 1'b0, 18'h0, 9'h0, 1'b0});
                    e      = sb.pop_back();
                    sng_xs = '0;
                    abort  = 1'b0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    check_eq("post_rst_ready", req_ready, 1);
                    was_reset = 1'b1;
                end
                idx++;
            end
        end while (!rsp_valid && !was_reset && cnt < 1000);
        sng_xs = '0;
        abort  = 1'b0;
        if (!was_reset) begin
            check_eq("rsp_valid_seen", rsp_valid, 1);
            check_eq("latency", cnt, sb[sb.size()-1].lat);
            check_eq("sng_rst_low_cycles", low, 1);
        end
    endtask

    task automatic respond(input int hold, input bit pend, input logic [15:0] bxs, input logic [8:0] len,
                           input int o0, input int o1, input int ab);
        exp_t e;
        e = sb.pop_front();
        check_eq("sng_bxs_hold", sng_bxs, cur_bxs);
        rsp_ready = 1'b0;
        if (pend) begin
            prep_req(bxs, len, o0, o1, ab);
        end
        for (int k = 0; k < hold; k++) begin
            check_eq("hold_rsp", {rsp_valid, rsp_counts, rsp_cycles, rsp_aborted}, {1'b1, e.c1, e.c0, e.cyc, e.ab});
            if (pend) begin
                check_eq("hold_req_ready", req_ready, 0);
            end
            @(negedge clk);
        end
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_count0", rsp_counts[8:0], e.c0);
        check_eq("rsp_count1", rsp_counts[17:9], e.c1);
        check_eq("rsp_cycles", rsp_cycles, e.cyc);
        check_eq("rsp_aborted", rsp_aborted, e.ab);
        check_eq("req_ready_in_done", req_ready, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_valid_after_hs", rsp_valid, 0);
        check_eq("req_ready_after_hs", req_ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_req_ready", req_ready, 1);
        check_eq("reset_sng_rst_n", sng_rst_n, 1);
        check_eq("reset_sng_bxs", sng_bxs, 0);
        check_eq("reset_rsp", {rsp_valid, rsp_counts, rsp_cycles, rsp_aborted}, 0);

        start_req(16'h80C0, 9'd0, 192, 128, 0);
        run_wait(0);
        respond(0, 1'b0, 16'h0, 9'd0, 0, 0, 0);

        start_req(16'h1234, 9'd16, 300, 300, 0);
        run_wait(0);
        respond(3, 1'b0, 16'h0, 9'd0, 0, 0, 0);

        start_req(16'h5566, 9'd100, 300, 0, 40);
        run_wait(0);
        respond(0, 1'b0, 16'h0, 9'd0, 0, 0, 0);

        start_req(16'hA5A5, 9'd8, 5, 3, 8);
        run_wait(0);
        respond(0, 1'b0, 16'h0, 9'd0, 0, 0, 0);

        start_req(16'h0102, 9'd300, 10, 20, 0);
        run_wait(0);
        respond(0, 1'b0, 16'h0, 9'd0, 0, 0, 0);

        start_req(16'h0F0F, 9'd12, 7, 12, 0);
        run_wait(0);
        respond(20, 1'b1, 16'hF0F0, 9'd20, 4, 9, 0);
        run_wait(0);
        respond(0, 1'b0, 16'h0, 9'd0, 0, 0, 0);

        start_req(16'h3344, 9'd100, 300, 300, 0);
        run_wait(50);
        check_eq("reset_discard", was_reset, 1);
        start_req(16'h7788, 9'd30, 11, 25, 0);
        run_wait(0);
        respond(0, 1'b0, 16'h0, 9'd0, 0, 0, 0);

        check_eq("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
